match_event_logger: RTL and testbench

- Downstream consumer of the overlapping "010"/"1001" sequence detector's single-cycle Mealy match pulse.
- Timestamps each match against a free-running cycle counter and buffers the timestamps in a small first-word-fall-through FIFO.
- Software or a debug bus drains the FIFO through a valid/ready handshake.
- Also keeps a saturating total-match counter and a sticky overflow flag.

---
 rtl/match_event_logger_pkg.sv | 12 +
 rtl/match_event_logger_ts_fifo.sv | 54 +++++
 rtl/match_event_logger.sv | 63 ++++++
 tb/tb_match_event_logger.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/match_event_logger_pkg.sv
// Shared defaults for the match event logger and its timestamp FIFO.
package match_event_logger_pkg;
  localparam int TS_W_DEF       = 16;
  localparam int CNT_W_DEF      = 12;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int CNT_SAT_DEF    = (1 << CNT_W_DEF) - 1;

  // Saturation value for a counter of the given width.
  function automatic int sat_value(input int w);
    return (1 << w) - 1;
  endfunction
endpackage

// File: rtl/match_event_logger_ts_fifo.sv
// First-word-fall-through timestamp FIFO with separate occupancy counter.
module ts_fifo
  import match_event_logger_pkg::*;
#(
  parameter  int W      = TS_W_DEF,
  parameter  int DEPTH  = FIFO_DEPTH_DEF,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  output logic          full,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          empty,
  output logic [AW:0]   level
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/match_event_logger.sv
// Timestamps detector match pulses into a FWFT FIFO; keeps a saturating
// match count and a sticky overflow flag.
module match_event_logger
  import match_event_logger_pkg::*;
#(
  parameter  int TS_W       = TS_W_DEF,
  parameter  int CNT_W      = CNT_W_DEF,
  parameter  int FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int ADDR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              match_in,
  input  logic              clear,
  output logic              ts_valid,
  input  logic              ts_ready,
  output logic [TS_W-1:0]   ts_data,
  output logic [ADDR_W:0]   fifo_level,
  output logic [CNT_W-1:0]  match_count,
  output logic              overflow
);
  localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

  logic [TS_W-1:0] ts_cnt;
  logic            full, empty, accept, push, pop;

  // Dropped only when full and the head is not leaving this cycle.
  assign accept   = match_in && (!full || ts_ready);
  assign push     = accept && !clear;
  assign pop      = ts_ready && !clear;
  assign ts_valid = !empty;

  ts_fifo #(.W(TS_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (push),
    .wdata (ts_cnt),
    .full  (full),
    .pop   (pop),
    .rdata (ts_data),
    .empty (empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_cnt      <= '0;
      match_count <= '0;
      overflow    <= 1'b0;
    end else if (clear) begin
      ts_cnt      <= '0;
      match_count <= '0;
      overflow    <= 1'b0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      if (match_in) begin
        if (match_count != CNT_SAT) match_count <= match_count + 1'b1;
        if (!accept) overflow <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_match_event_logger.sv
// Randomized and directed checks of match_event_logger against a queue model.
module tb_match_event_logger;
  localparam int TS_W = 16, CNT_W = 12, DEPTH = 8;
  localparam int TS_MOD = 65536, SAT = 4095;

  logic        clk = 1'b0;
  logic        reset, match_in, clear, ts_ready;
  logic        ts_valid, overflow;
  logic [15:0] ts_data;
  logic [3:0]  fifo_level;
  logic [11:0] match_count;

  int m_ts, m_cnt, m_ovf;
  int m_q[$];
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  match_event_logger #(.TS_W(TS_W), .CNT_W(CNT_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .match_in(match_in), .clear(clear),
    .ts_valid(ts_valid), .ts_ready(ts_ready), .ts_data(ts_data),
    .fifo_level(fifo_level), .match_count(match_count), .overflow(overflow)
  );

  task automatic model_reset();
    m_ts = 0; m_cnt = 0; m_ovf = 0; m_q.delete();
  endtask

  // Model of one clock edge from the sampled inputs.
  task automatic model_edge();
    if (clear) begin
      model_reset();
    end else begin
      if (ts_ready && m_q.size() > 0) void'(m_q.pop_front());
      if (match_in) begin
        if (m_cnt < SAT) m_cnt++;
        if (m_q.size() == DEPTH) m_ovf = 1;
        else m_q.push_back(m_ts);
      end
      m_ts = (m_ts + 1) % TS_MOD;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_clear();
    clear = 1; match_in = 0; ts_ready = 0;
    tick();
    clear = 0;
  endtask

  task automatic test_reset();
    reset = 0; match_in = 0; clear = 0; ts_ready = 0;
    model_reset();
    #12;
    n_cmp++; if (ts_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", ts_valid); end
    n_cmp++; if (fifo_level !== 4'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    n_cmp++; if (ts_data !== 16'd0) begin n_err++; $display("FAIL reset_data got %0d want 0", ts_data); end
    n_cmp++; if (match_count !== 12'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", match_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %0b want 0", overflow); end
    match_in = 1;
    @(posedge clk); #1;
    n_cmp++; if (match_count !== 12'd0) begin n_err++; $display("FAIL reset_hold_count got %0d want 0", match_count); end
    match_in = 0;
    @(negedge clk); reset = 1;
  endtask

  task automatic test_basic();
    do_clear();
    while (m_ts != 5) tick();
    n_cmp++; if (ts_valid !== 1'b0) begin n_err++; $display("FAIL basic_pre_valid got %0b want 0", ts_valid); end
    match_in = 1; tick(); match_in = 0;
    n_cmp++; if (ts_valid !== 1'b1 || ts_data !== 16'd5) begin n_err++; $display("FAIL basic_first got v=%0b d=%0d want v=1 d=5", ts_valid, ts_data); end
    while (m_ts != 9) tick();
    match_in = 1; tick(); match_in = 0;
    n_cmp++; if (fifo_level !== 4'd2) begin n_err++; $display("FAIL basic_level got %0d want 2", fifo_level); end
    ts_ready = 1;
    n_cmp++; if (ts_data !== 16'd5) begin n_err++; $display("FAIL basic_read0 got %0d want 5", ts_data); end
    tick();
    n_cmp++; if (ts_data !== 16'd9) begin n_err++; $display("FAIL basic_read1 got %0d want 9", ts_data); end
    tick(); ts_ready = 0;
    n_cmp++; if (ts_valid !== 1'b0) begin n_err++; $display("FAIL basic_empty got %0b want 0", ts_valid); end
    n_cmp++; if (match_count !== 12'd2 || overflow !== 1'b0) begin n_err++; $display("FAIL basic_cnt got c=%0d o=%0b want c=2 o=0", match_count, overflow); end
  endtask

  task automatic test_overflow();
    do_clear();
    while (m_ts != 20) tick();
    match_in = 1; repeat (10) tick(); match_in = 0;
    n_cmp++; if (fifo_level !== 4'd8) begin n_err++; $display("FAIL ovf_level got %0d want 8", fifo_level); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %0b want 1", overflow); end
    n_cmp++; if (match_count !== 12'd10) begin n_err++; $display("FAIL ovf_count got %0d want 10", match_count); end
    tick();
    n_cmp++; if (ts_data !== 16'd20) begin n_err++; $display("FAIL ovf_stable got %0d want 20", ts_data); end
    ts_ready = 1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (ts_valid !== 1'b1 || ts_data !== 16'(20 + i)) begin n_err++; $display("FAIL ovf_drain%0d got v=%0b d=%0d want v=1 d=%0d", i, ts_valid, ts_data, 20 + i); end
      tick();
    end
    ts_ready = 0;
    n_cmp++; if (ts_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty got %0b want 0", ts_valid); end
  endtask

  task automatic test_back_to_back();
    int t0;
    do_clear();
    repeat (3) tick();
    t0 = m_ts;
    match_in = 1; repeat (8) tick();
    n_cmp++; if (fifo_level !== 4'd8) begin n_err++; $display("FAIL b2b_fill got %0d want 8", fifo_level); end
    ts_ready = 1; tick(); match_in = 0; ts_ready = 0;
    n_cmp++; if (fifo_level !== 4'd8) begin n_err++; $display("FAIL b2b_level got %0d want 8", fifo_level); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL b2b_ovf got %0b want 0", overflow); end
    n_cmp++; if (ts_data !== 16'(t0 + 1)) begin n_err++; $display("FAIL b2b_head got %0d want %0d", ts_data, t0 + 1); end
  endtask

  task automatic test_saturate();
    do_clear();
    match_in = 1;
    repeat (4094) tick();
    n_cmp++; if (match_count !== 12'd4094) begin n_err++; $display("FAIL sat_pre got %0d want 4094", match_count); end
    tick();
    n_cmp++; if (match_count !== 12'd4095) begin n_err++; $display("FAIL sat_hit got %0d want 4095", match_count); end
    repeat (105) tick();
    match_in = 0;
    n_cmp++; if (match_count !== 12'd4095) begin n_err++; $display("FAIL sat_hold got %0d want 4095", match_count); end
  endtask

  task automatic test_clear();
    do_clear();
    match_in = 1; repeat (9) tick(); match_in = 0;
    ts_ready = 1; repeat (5) tick(); ts_ready = 0;
    n_cmp++; if (fifo_level !== 4'd3 || overflow !== 1'b1) begin n_err++; $display("FAIL clr_setup got l=%0d o=%0b want l=3 o=1", fifo_level, overflow); end
    clear = 1; match_in = 1; ts_ready = 1; tick(); clear = 0; ts_ready = 0;
    n_cmp++; if (fifo_level !== 4'd0 || ts_valid !== 1'b0) begin n_err++; $display("FAIL clr_fifo got l=%0d v=%0b want l=0 v=0", fifo_level, ts_valid); end
    n_cmp++; if (match_count !== 12'd0 || overflow !== 1'b0) begin n_err++; $display("FAIL clr_state got c=%0d o=%0b want c=0 o=0", match_count, overflow); end
    tick(); match_in = 0;
    n_cmp++; if (ts_data !== 16'd0 || match_count !== 12'd1) begin n_err++; $display("FAIL clr_restart got d=%0d c=%0d want d=0 c=1", ts_data, match_count); end
  endtask

  task automatic test_random();
    int exp_data;
    do_clear();
    for (int i = 0; i < 400; i++) begin
      match_in = 1'($urandom % 2);
      ts_ready = ($urandom % 3 == 0);
      clear    = ($urandom % 60 == 0);
      tick();
      exp_data = (m_q.size() > 0) ? m_q[0] : 0;
      n_cmp++; if (ts_valid !== (m_q.size() > 0)) begin n_err++; $display("FAIL rnd_valid@%0d got %0b want %0b", i, ts_valid, m_q.size() > 0); end
      n_cmp++; if (fifo_level !== 4'(m_q.size())) begin n_err++; $display("FAIL rnd_level@%0d got %0d want %0d", i, fifo_level, m_q.size()); end
      n_cmp++; if (ts_data !== 16'(exp_data)) begin n_err++; $display("FAIL rnd_data@%0d got %0d want %0d", i, ts_data, exp_data); end
      n_cmp++; if (match_count !== 12'(m_cnt)) begin n_err++; $display("FAIL rnd_count@%0d got %0d want %0d", i, match_count, m_cnt); end
      n_cmp++; if (overflow !== 1'(m_ovf)) begin n_err++; $display("FAIL rnd_ovf@%0d got %0b want %0d", i, overflow, m_ovf); end
    end
    match_in = 0; ts_ready = 0; clear = 0;
  endtask

  task automatic test_reset_wrap();
    do_clear();
    match_in = 1; repeat (4) tick(); match_in = 0;
    n_cmp++; if (fifo_level !== 4'd4) begin n_err++; $display("FAIL rw_setup got %0d want 4", fifo_level); end
    @(negedge clk); #2 reset = 0; #1;
    n_cmp++; if (ts_valid !== 1'b0 || fifo_level !== 4'd0) begin n_err++; $display("FAIL rw_async got v=%0b l=%0d want v=0 l=0", ts_valid, fifo_level); end
    model_reset();
    @(negedge clk); reset = 1;
    while (m_ts != TS_MOD - 1) tick();
    match_in = 1; tick();
    n_cmp++; if (ts_data !== 16'd65535) begin n_err++; $display("FAIL rw_top got %0d want 65535", ts_data); end
    ts_ready = 1; tick(); match_in = 0; ts_ready = 0;
    n_cmp++; if (ts_data !== 16'd0 || fifo_level !== 4'd1) begin n_err++; $display("FAIL rw_wrap got d=%0d l=%0d want d=0 l=1", ts_data, fifo_level); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_saturate();
    test_clear();
    test_random();
    test_reset_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
